host_bus_arb: RTL and testbench

Two-master, one-slave bus arbiter on the NEXYS4_DDR host bus. It shares the CSR/test-memory fabric (CSR LED 0x00000000, CSR SW 0x00000004, test memory 0x80000000+) between the UDM UART debug master (m0) and a second on-chip master (m1). Arbitration is round-robin and one transaction is outstanding at a time. Grant is held from request through write-ack or read-response. An optional watchdog completes transactions the slave never answers.

---
 rtl/host_bus_arb.sv | 187 ++++++++++++++++++
 tb/tb_host_bus_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_arb.sv
// Round-robin two-master / one-slave host bus arbiter, one outstanding transaction.
// Optional slave watchdog enabled by defining ARB_TIMEOUT_EN.
module host_bus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_resp,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_resp,
  output logic [31:0] m1_rdata,

  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [3:0]  s_be,
  output logic [31:0] s_wdata,
  input  logic        s_ack,
  input  logic        s_resp,
  input  logic [31:0] s_rdata,

  output logic        timeout_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        gnt;
  logic        gnt_nxt;
  logic        last_gnt;
  logic        last_gnt_nxt;
  logic        force_cpl;
  logic        force_nxt;
  logic        tmo_hit;

  logic        sel_req;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;

  logic        in_addr;
  logic        in_rdata;
  logic        ack_evt;
  logic        resp_evt;
  logic        tmo_evt;
  logic [31:0] cpl_rdata;

  // Request mux driven purely by the registered grant
  always_comb begin
    sel_req   = m0_req;
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_be    = m0_be;
    sel_wdata = m0_wdata;
    if (gnt) begin
      sel_req   = m1_req;
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_be    = m1_be;
      sel_wdata = m1_wdata;
    end
  end

  assign in_addr  = (state == ADDR);
  assign in_rdata = (state == RDATA);

  // A real slave handshake in the limit cycle takes precedence over the watchdog
  assign ack_evt   = in_addr && sel_req && (s_ack || tmo_hit);
  assign resp_evt  = in_rdata && (s_resp || tmo_hit || force_cpl);
  assign tmo_evt   = (in_addr && sel_req && !s_ack && tmo_hit) ||
                     (in_rdata && !s_resp && tmo_hit);
  assign cpl_rdata = s_resp ? s_rdata : TIMEOUT_RDATA;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      force_cpl <= 1'b0;
    end else begin
      force_cpl <= force_nxt;
      if ((state_nxt != state) && (state_nxt != IDLE)) begin
        tmo_cnt <= '0;
      end else if (in_addr || in_rdata) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

  // The forced read completion cycle must not raise a second watchdog event
  assign tmo_hit = (in_addr || in_rdata) && (tmo_cnt == TMO_LIMIT) && !force_cpl;
`else
  logic unused_cfg;

  assign tmo_hit    = 1'b0;
  assign force_cpl  = 1'b0;
  assign unused_cfg = ^{16'(TIMEOUT_CYCLES), force_nxt};
`endif

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    force_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master not served last wins
          gnt_nxt      = (m0_req && m1_req) ? !last_gnt : m1_req;
          last_gnt_nxt = gnt_nxt;
          state_nxt    = ADDR;
        end
      end
      ADDR: begin
        if (!sel_req) begin
          state_nxt = IDLE;
        end else if (ack_evt) begin
          if (sel_we) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RDATA;
            force_nxt = !s_ack;
          end
        end
      end
      RDATA: begin
        if (resp_evt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Slave side is only driven while the address phase is open
  assign s_req   = in_addr && sel_req && !tmo_hit;
  assign s_we    = in_addr && sel_we;
  assign s_addr  = in_addr ? sel_addr  : '0;
  assign s_be    = in_addr ? sel_be    : '0;
  assign s_wdata = in_addr ? sel_wdata : '0;

  assign m0_ack   = ack_evt && !gnt;
  assign m1_ack   = ack_evt && gnt;
  assign m0_resp  = resp_evt && !gnt;
  assign m1_resp  = resp_evt && gnt;
  assign m0_rdata = m0_resp ? cpl_rdata : '0;
  assign m1_rdata = m1_resp ? cpl_rdata : '0;

  assign timeout_o = tmo_evt;

endmodule

// File: tb/tb_host_bus_arb.sv
// Scoreboard bench for host_bus_arb; expected ack/resp/timeout events are
// queued with their cycle stamps and matched by a negedge monitor.
module tb_host_bus_arb;

  localparam int K_M0ACK  = 0;
  localparam int K_M1ACK  = 1;
  localparam int K_M0RESP = 2;
  localparam int K_M1RESP = 3;
  localparam int K_TMO    = 4;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_BUILD = 1'b1;
`else
  localparam bit TMO_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_ack, s_resp;
  logic [31:0] s_rdata;
  logic        timeout_o;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  cyc          = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  host_bus_arb #(
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_RDATA (32'hDEADBEEF)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_be    (m0_be),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_resp  (m0_resp),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_be    (m1_be),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_resp  (m1_resp),
    .m1_rdata (m1_rdata),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_be     (s_be),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_resp   (s_resp),
    .s_rdata  (s_rdata),
    .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input int kind, input int c, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_cycle", 32'(cyc), 32'(e.cyc));
      if (kind == K_M0RESP || kind == K_M1RESP) check("sb_rdata", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (m0_ack)    sb_pop(K_M0ACK, 32'h0);
    if (m1_ack)    sb_pop(K_M1ACK, 32'h0);
    if (m0_resp)   sb_pop(K_M0RESP, m0_rdata);
    if (m1_resp)   sb_pop(K_M1RESP, m1_rdata);
    if (timeout_o) sb_pop(K_TMO, 32'h0);
    if (m0_ack || m1_ack || m0_resp || m1_resp)
      check("ack_resp_exclusive", 32'((m0_ack || m1_ack) && (m0_resp || m1_resp)), 32'h0);
    if (m0_resp) check("m1_rdata_quiet", m1_rdata, 32'h0);
    if (m1_resp) check("m0_rdata_quiet", m0_rdata, 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    s_ack  = 1'b0; s_resp = 1'b0; s_rdata = '0;
  endtask

  // Both masters keep write requests up; zero-wait slave acks every address phase
  task automatic run_ties(input int n);
    int t0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0000; m0_be = 4'hF; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0004; m1_be = 4'hF; m1_wdata = 32'h2;
    s_ack  = 1'b1;
    t0 = cyc;
    for (int i = 0; i < n; i++) sb_push((i % 2 == 0) ? K_M0ACK : K_M1ACK, t0 + 1 + 2 * i, 32'h0);
    for (int k = 1; k <= 2 * n; k++) begin
      step();
      if (k % 2 == 1) check("tie_grant_addr", s_addr, ((k / 2) % 2 == 1) ? 32'h4 : 32'h0);
    end
    clr_inputs();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int a;
    clr_inputs();
    rst_i = 1'b1;
    repeat (3) step();
    check("rst_s_req", 32'(s_req), 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_acks", 32'({m0_ack, m1_ack, m0_resp, m1_resp}), 32'h0);
    check("rst_timeout", 32'(timeout_o), 32'h0);
    rst_i = 1'b0;
    step();

    // m0 write with a zero-wait slave
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h8000_00FF; m0_be = 4'hF; m0_wdata = 32'h41C8_0000;
    #1 check("t1_arb_latency", 32'(s_req), 32'h0);
    step();
    check("t1_s_req", 32'(s_req), 32'h1);
    check("t1_s_we", 32'(s_we), 32'h1);
    check("t1_s_addr", s_addr, 32'h8000_00FF);
    check("t1_s_wdata", s_wdata, 32'h41C8_0000);
    check("t1_s_be", 32'(s_be), 32'hF);
    s_ack = 1'b1;
    sb_push(K_M0ACK, cyc, 32'h0);
    step();
    clr_inputs();
    #1 check("t1_idle_s_req", 32'(s_req), 32'h0);
    step();

    // m1 read, response three cycles after the ack
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0F00; m1_be = 4'hF;
    step();
    check("t2_s_addr", s_addr, 32'h8000_0F00);
    check("t2_s_we", 32'(s_we), 32'h0);
    s_ack = 1'b1;
    sb_push(K_M1ACK, cyc, 32'h0);
    step();
    clr_inputs();
    #1 check("t2_rdata_s_req", 32'(s_req), 32'h0);
    repeat (3) step();
    s_resp = 1'b1; s_rdata = 32'h1234_5678;
    sb_push(K_M1RESP, cyc, 32'h1234_5678);
    step();
    // stray handshakes while idle must be ignored
    s_resp = 1'b1; s_ack = 1'b1; s_rdata = 32'hBAD0_BAD0;
    step();
    clr_inputs();
    step();

    // Round-robin directly after reset: m0, m1, m0, m1
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    run_ties(4);

    // Reset while a read is in RDATA
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8000_0010; m0_be = 4'hF;
    step();
    s_ack = 1'b1;
    sb_push(K_M0ACK, cyc, 32'h0);
    step();
    clr_inputs();
    s_resp = 1'b1; s_rdata = 32'hCAFE_F00D;
    rst_i = 1'b1;
    #1;
    check("t4_rst_m0_resp", 32'(m0_resp), 32'h0);
    check("t4_rst_m0_rdata", m0_rdata, 32'h0);
    check("t4_rst_s_side", 32'({s_req, s_we, s_be}), 32'h0);
    check("t4_rst_timeout", 32'(timeout_o), 32'h0);
    step();
    clr_inputs();
    rst_i = 1'b0;
    step();
    run_ties(2);

    // Slave acks a read but never responds
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8000_0020; m0_be = 4'hF;
    step();
    s_ack = 1'b1;
    a = cyc;
    sb_push(K_M0ACK, a, 32'h0);
    if (TMO_BUILD) begin
      sb_push(K_M0RESP, a + 16, 32'hDEAD_BEEF);
      sb_push(K_TMO, a + 16, 32'h0);
      sb_push(K_M1ACK, a + 33, 32'h0);
      sb_push(K_TMO, a + 33, 32'h0);
    end
    step();
    clr_inputs();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0004; m1_be = 4'h1; m1_wdata = 32'h5;
    for (int k = 2; k <= 40; k++) begin
      step();
      if (k == 16) check("t5_timeout_at_limit", 32'(timeout_o), 32'(TMO_BUILD));
      if (k == 32) check("t5_s_req_before_limit", 32'(s_req), 32'(TMO_BUILD));
      if (k == 33) check("t5_s_req_at_limit", 32'(s_req), 32'h0);
      if (k == 34 && TMO_BUILD) m1_req = 1'b0;
    end
    check("t5_final_s_req", 32'(s_req), 32'h0);
    check("t5_final_timeout", 32'(timeout_o), 32'h0);
    rst_i = 1'b1;
    clr_inputs();
    step();
    rst_i = 1'b0;
    repeat (2) step();

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
